// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared encodings for the data memory controller: request size codes and
// the controller FSM state type. Imported by dmem_align and data_mem_ctrl.
// ---------------------------------------------------------------------------
package dmem_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_align.sv
// ---------------------------------------------------------------------------
// dmem_align
// Purely combinational alignment helper for data_mem_ctrl.
//   size        : access size (SZ_BYTE / SZ_HALF / SZ_WORD / reserved)
//   is_unsigned : zero-extend (1) or sign-extend (0) sub-word loads
//   addr_lo     : byte offset within the 32-bit word
//   wdata       : right-aligned store data
//   mem_rdata   : full word read from the storage array
//   misaligned  : request is misaligned or uses the reserved size
//   byte_en     : per-lane write enables (all zero when misaligned)
//   wdata_lanes : store data replicated onto every lane it may target
//   load_data   : addressed lane(s) shifted down and extended
// ---------------------------------------------------------------------------
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic        misaligned,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Alignment check and byte-enable generation
  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b0000;
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << addr_lo;
      SZ_HALF: begin
        if (addr_lo[0]) misaligned = 1'b1;
        else            byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        if (addr_lo != 2'b00) misaligned = 1'b1;
        else                  byte_en    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Replicating the store data means the enabled lanes always see the
  // right bytes regardless of offset, so no shifter is needed on writes.
  always_comb begin
    case (size)
      SZ_BYTE: wdata_lanes = {4{wdata[7:0]}};
      SZ_HALF: wdata_lanes = {2{wdata[15:0]}};
      default: wdata_lanes = wdata;
    endcase
  end

  // Load extraction: an aligned word has offset 0, so the shift is a no-op
  always_comb begin
    shifted = mem_rdata >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = is_unsigned ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Single-port 32-bit data memory with a valid/ready request channel and a
// valid/ready response channel. Optional extra access latency.
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous active-low reset (memory contents are kept)
//   req_valid    : request present        req_ready  : accepting (IDLE only)
//   req_we       : 1 store / 0 load       req_size   : byte / half / word
//   req_unsigned : zero-extend loads      req_addr   : byte address
//   req_wdata    : right-aligned store data
//   resp_valid   : response present       resp_ready : consumer accepts
//   resp_rdata   : extended load data     resp_err   : misaligned/reserved
// DEPTH_WORDS must be a power of two (>= 2); WAIT_CYCLES is 0..15.
// ---------------------------------------------------------------------------
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 8192,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state;
  state_t        state_next;
  logic [3:0]    wait_cnt;

  logic          req_we_q;
  logic [1:0]    req_size_q;
  logic          req_unsigned_q;
  logic [AW+1:0] req_addr_q;
  logic [31:0]   req_wdata_q;

  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS] = '{default: '0};

  logic          in_idle;
  logic          accept;
  logic          enter_resp;
  logic          act_we;
  logic [1:0]    act_size;
  logic          act_unsigned;
  logic [AW+1:0] act_addr;
  logic [31:0]   act_wdata;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_word;
  logic          misaligned;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lanes;
  logic [31:0]   load_data;
  logic          mem_we;
  logic          unused_addr_hi;

  assign in_idle = (state == ST_IDLE);
  assign accept  = in_idle && req_valid;

  // With no wait cycles the accept edge is also the commit edge, so the
  // datapath works on the live request in IDLE and the captured one after.
  assign act_we       = in_idle ? req_we          : req_we_q;
  assign act_size     = in_idle ? req_size        : req_size_q;
  assign act_unsigned = in_idle ? req_unsigned    : req_unsigned_q;
  assign act_addr     = in_idle ? req_addr[AW+1:0] : req_addr_q;
  assign act_wdata    = in_idle ? req_wdata       : req_wdata_q;

  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == ST_BUSY) && (wait_cnt == 4'd0));

  // Upper address bits wrap away; they are deliberately ignored
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign word_idx = act_addr[AW+1:2];
  assign mem_word = mem[word_idx];
  assign mem_we   = reset && enter_resp && act_we && !misaligned;

  dmem_align u_align (
    .size        (act_size),
    .is_unsigned (act_unsigned),
    .addr_lo     (act_addr[1:0]),
    .wdata       (act_wdata),
    .mem_rdata   (mem_word),
    .misaligned  (misaligned),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid) state_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (wait_cnt == 4'd0) state_next = ST_RESP;
      ST_RESP: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs; response fields are forced to zero outside RESP
  always_comb begin
    req_ready  = in_idle;
    resp_valid = (state == ST_RESP);
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    if (state == ST_RESP) begin
      resp_rdata = rdata_q;
      resp_err   = err_q;
    end
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt       <= 4'd0;
      req_we_q       <= 1'b0;
      req_size_q     <= SZ_BYTE;
      req_unsigned_q <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= 32'd0;
      rdata_q        <= 32'd0;
      err_q          <= 1'b0;
    end else begin
      if (accept) begin
        req_we_q       <= req_we;
        req_size_q     <= req_size;
        req_unsigned_q <= req_unsigned;
        req_addr_q     <= req_addr[AW+1:0];
        req_wdata_q    <= req_wdata;
        wait_cnt       <= 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
      end else if ((state == ST_BUSY) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (enter_resp) begin
        err_q   <= misaligned;
        rdata_q <= (act_we || misaligned) ? 32'd0 : load_data;
      end else if ((state == ST_RESP) && resp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // Storage array: never reset, written only through the byte enables
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Drives two controllers (no wait cycles and three wait cycles) with directed
// and random transactions and compares every response against a byte-level
// reference memory held in the bench.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH = 8192;
  localparam int BYTES = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset        [2];
  logic        req_valid    [2];
  wire         req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  wire         resp_valid   [2];
  logic        resp_ready   [2];
  wire  [31:0] resp_rdata   [2];
  wire         resp_err     [2];

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  int vecs = 0;
  int errs = 0;

  // Reference memory, one byte per address, per controller
  bit [7:0] refMem [2][BYTES];

  logic [31:0] rd;
  logic        er;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: model prediction, issue, latency, hold, consume.
  // While the request is in flight a decoy store to 0x300 is held on the
  // request bus; it must never be accepted.
  task automatic applyStimulus(input int d, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input int hold,
                               output logic [31:0] rdata, output logic err);
    int          base;
    int          lat;
    int          nBytes;
    logic [31:0] expData;
    logic        expErr;

    base   = int'(addr % BYTES);
    expErr = (size == SZ_RSVD) || (size == SZ_HALF && addr[0]) ||
             (size == SZ_WORD && addr[1:0] != 2'b00);
    nBytes = (size == SZ_BYTE) ? 1 : (size == SZ_HALF) ? 2 : 4;
    expData = 32'd0;
    if (!expErr && !we) begin
      for (int i = 0; i < nBytes; i++) expData[8*i +: 8] = refMem[d][base + i];
      if (!uns && size == SZ_BYTE && expData[7])  expData |= 32'hFFFF_FF00;
      if (!uns && size == SZ_HALF && expData[15]) expData |= 32'hFFFF_0000;
    end

    @(negedge clk);
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    checkOutput("req_ready_idle", {31'd0, req_ready[d]}, 32'd1);

    @(posedge clk); #1;
    req_we[d]    = 1'b1;
    req_size[d]  = SZ_WORD;
    req_addr[d]  = 32'h300;
    req_wdata[d] = 32'hFFFF_FFFF;

    lat = 1;
    while (!resp_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, (d == 0) ? 32'd1 : 32'd4);
    checkOutput("ready_in_resp", {31'd0, req_ready[d]}, 32'd0);
    rdata = resp_rdata[d];
    err   = resp_err[d];
    checkOutput("rdata", rdata, expData);
    checkOutput("err", {31'd0, err}, {31'd0, expErr});

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", {31'd0, resp_valid[d]}, 32'd1);
      checkOutput("hold_rdata", resp_rdata[d], rdata);
      checkOutput("hold_err", {31'd0, resp_err[d]}, {31'd0, err});
      checkOutput("hold_ready", {31'd0, req_ready[d]}, 32'd0);
    end

    @(negedge clk);
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b0;
    checkOutput("post_valid", {31'd0, resp_valid[d]}, 32'd0);
    checkOutput("post_ready", {31'd0, req_ready[d]}, 32'd1);
    checkOutput("post_rdata", resp_rdata[d], 32'd0);

    if (we && !expErr)
      for (int i = 0; i < nBytes; i++) refMem[d][base + i] = wdata[8*i +: 8];
  endtask

  initial begin
    // Reset with a store pending on the bus: it must not be taken
    for (int d = 0; d < 2; d++) begin
      reset[d]        = 1'b0;
      req_valid[d]    = 1'b1;
      req_we[d]       = 1'b1;
      req_size[d]     = SZ_WORD;
      req_unsigned[d] = 1'b0;
      req_addr[d]     = 32'h200;
      req_wdata[d]    = 32'hFFFF_FFFF;
      resp_ready[d]   = 1'b0;
    end
    repeat (3) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checkOutput("rst_valid", {31'd0, resp_valid[d]}, 32'd0);
        checkOutput("rst_ready", {31'd0, req_ready[d]}, 32'd1);
        checkOutput("rst_rdata", resp_rdata[d], 32'd0);
        checkOutput("rst_err", {31'd0, resp_err[d]}, 32'd0);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      reset[d]     = 1'b1;
    end

    // Store aborted by reset in the second BUSY cycle
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_size[1]  = SZ_WORD;
    req_addr[1]  = 32'h40;
    req_wdata[1] = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    checkOutput("abort_busy", {31'd0, req_ready[1]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset[1] = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_valid", {31'd0, resp_valid[1]}, 32'd0);
    checkOutput("abort_idle", {31'd0, req_ready[1]}, 32'd1);
    @(negedge clk);
    reset[1] = 1'b1;
    repeat (4) @(posedge clk);
    applyStimulus(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'd0, 0, rd, er);
    checkOutput("abort_lw", rd, 32'h0000_0000);

    // Long hold on a slow load
    applyStimulus(1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'd0, 5, rd, er);

    // Directed byte/half/word sequence on the zero-wait controller
    applyStimulus(0, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF, 0, rd, er);
    applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'd0, 1, rd, er);
    checkOutput("lw_dead", rd, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b1, SZ_BYTE, 1'b0, 32'h102, 32'h0000_007F, 0, rd, er);
    applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'd0, 0, rd, er);
    checkOutput("lw_sb", rd, 32'hDE7F_BEEF);
    applyStimulus(0, 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'd0, 0, rd, er);
    checkOutput("lb", rd, 32'hFFFF_FFDE);
    applyStimulus(0, 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'd0, 0, rd, er);
    checkOutput("lbu", rd, 32'h0000_00DE);
    applyStimulus(0, 1'b0, SZ_HALF, 1'b0, 32'h102, 32'd0, 0, rd, er);
    checkOutput("lh", rd, 32'hFFFF_DE7F);
    applyStimulus(0, 1'b1, SZ_HALF, 1'b0, 32'h101, 32'h0000_1111, 0, rd, er);
    checkOutput("sh_mis_err", {31'd0, er}, 32'd1);
    checkOutput("sh_mis_rdata", rd, 32'd0);
    applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'd0, 0, rd, er);
    checkOutput("lw_after_mis", rd, 32'hDE7F_BEEF);
    applyStimulus(0, 1'b1, SZ_WORD, 1'b0, 32'h8004, 32'hA5A5_A5A5, 0, rd, er);
    applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 32'h0004, 32'd0, 0, rd, er);
    checkOutput("lw_wrap", rd, 32'hA5A5_A5A5);

    // Random traffic on both controllers in a small window with wrapped aliases
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        int          r;
        logic [1:0]  sz;
        logic [31:0] a;
        r  = $urandom_range(0, 9);
        sz = (r == 0) ? SZ_RSVD : 2'(r % 3);
        a  = ($urandom & 32'hFFFF_8000) | $urandom_range(0, 63);
        applyStimulus(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                      a, $urandom, $urandom_range(0, 2), rd, er);
      end
    end

    // Locations that only reset-time or decoy stores could have touched
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 1'b0, SZ_WORD, 1'b0, 32'h200, 32'd0, 0, rd, er);
      checkOutput("no_write_in_reset", rd, 32'd0);
      applyStimulus(d, 1'b0, SZ_WORD, 1'b0, 32'h300, 32'd0, 0, rd, er);
      checkOutput("no_decoy_write", rd, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 8192, number of 32-bit words; SHALL be a power of two.
REQ-002 Parameter WAIT_CYCLES, default 0, extra access-latency cycles, 0..15.
REQ-003 Port clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  controller can accept a request.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 Port req_unsigned  input  1  load zero-extend (1) or sign-extend (0).
REQ-010 Port req_addr  input  32  byte address.
REQ-011 Port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port resp_valid  output  1  response present.
REQ-013 Port resp_ready  input  1  consumer accepts response.
REQ-014 Port resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-015 Port resp_err  output  1  misaligned or reserved-size request.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge where state is IDLE and req_valid=1; all req_* fields SHALL be captured at that edge.
REQ-018 On accept, with WAIT_CYCLES=0 the next state SHALL be RESP; otherwise BUSY, with a counter loaded to WAIT_CYCLES-1.
REQ-019 In BUSY the counter SHALL decrement each cycle; the transition to RESP SHALL occur on the edge where it equals 0.
REQ-020 Load-to-response latency SHALL be 1+WAIT_CYCLES cycles from accept edge to first cycle with resp_valid=1.
REQ-021 In RESP resp_valid SHALL be 1 and resp_rdata/resp_err SHALL hold stable until the edge with resp_ready=1, which SHALL return state to IDLE.
REQ-022 A new request SHALL NOT be accepted in the cycle the response is consumed (no back-to-back overlap); the earliest next accept is the following edge.
REQ-023 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap modulo DEPTH_WORDS*4).
REQ-024 Half access with addr[0]=1, word access with addr[1:0]!=0, or req_size=11 SHALL set resp_err=1, return rdata 0 and leave memory unmodified.
REQ-025 A store SHALL write only the addressed bytes via byte enables (byte: 1 lane at addr[1:0]; half: lanes addr[1]*2 and +1; word: all four).
REQ-026 A store SHALL commit on the edge that enters RESP; a load SHALL sample memory on that same edge.
REQ-027 Load extraction SHALL select the addressed lane(s), shift right, and sign- or zero-extend per req_unsigned; req_unsigned SHALL be ignored for word loads.
REQ-028 In IDLE and BUSY resp_valid, resp_rdata and resp_err SHALL be 0.
REQ-029 Memory contents SHALL initialise to all zeros at time zero.

Reset
REQ-030 With reset=0 at a rising edge: state SHALL become IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 Reset in BUSY SHALL abort the request; a pending store SHALL NOT commit.
REQ-033 While reset=0, no request SHALL be accepted and no memory write SHALL occur.

Structure
REQ-034 Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings SHALL live in shared package dmem_pkg.
REQ-035 Lane selection, byte-enable generation, misalignment detection and load extension SHALL be a combinational sub-module dmem_align; the FSM, counter, request registers and storage array SHALL be in data_mem_ctrl.

Verification
REQ-036 SW 0xDEADBEEF @0x100, then LW @0x100 with WAIT_CYCLES=0 -> resp_valid one cycle after accept, rdata 0xDEADBEEF, err 0.
REQ-037 After REQ-036: SB 0x7F @0x102, LW @0x100 -> 0xDE7FBEEF; LB @0x103 -> 0xFFFFFFDE; LBU @0x103 -> 0x000000DE; LH @0x102 -> 0xFFFFDE7F.
REQ-038 SH @0x101, LW @0x100 (addr 0x101 misaligned) -> store gives err 1 and rdata 0; following LW @0x100 still returns the pre-store value.
REQ-039 WAIT_CYCLES=3: LW accepted at cycle N -> resp_valid first at N+4; hold resp_ready=0 for 5 cycles -> rdata stable, req_ready 0 throughout.
REQ-040 WAIT_CYCLES=3: SW 0x12345678 @0x40, reset=0 during second BUSY cycle -> IDLE next cycle, resp_valid 0, later LW @0x40 -> 0x00000000.
REQ-041 DEPTH_WORDS=8192: SW 0xA5A5A5A5 @0x8004 -> LW @0x0004 returns 0xA5A5A5A5 (wrap).
